fp_issue_sequencer: RTL and testbench
=====================================

Name: fp_issue_sequencer

Overview:
- In-order, single-outstanding instruction sequencer that sits directly upstream of the 32-bit floating-point ALU.
- Fetches 24-bit instructions from a synchronous instruction memory and reads operands from its own register file.
- Issues one operation to the ALU over a valid/ready handshake, waits for the result, and writes it back to the destination register.
- Replaces the free-running per-instruction ALU instantiation with one shared, sequenced ALU.

Parameters:
- NREG, 17: number of architectural registers; indices 0..NREG-1 are legal.
- IMEM_DEPTH, 16: instruction memory depth; PC width is $clog2(IMEM_DEPTH).
- DATA_W, 32: operand and result width (IEEE-754 single).
- TIMEOUT, 64: maximum cycles to wait for an ALU result (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a program run from PC 0. Honoured only in IDLE.
- prog_len  in  PCW+1  number of instructions to execute; 0 means done immediately.
- imem_addr  out  PCW  instruction address.
- imem_data  in  24  instruction word; valid one cycle after imem_addr.
- alu_a  out  DATA_W  operand A = rf[instr[23:19]].
- alu_b  out  DATA_W  operand B = rf[instr[18:14]].
- alu_op  out  5  opcode = instr[13:9], passed through unmodified.
- alu_valid  out  1  issue request.
- alu_ready  in  1  ALU accepts the operation.
- alu_res  in  DATA_W  result data.
- alu_res_valid  in  1  result strobe, one cycle wide.
- host_we  in  1  host register preload write; ignored while busy.
- host_addr  in  5  host write/read index.
- host_wdata  in  DATA_W  preload data.
- host_rdata  out  DATA_W  combinational rf[host_addr]; 0 if the index is >= NREG.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the program completes.
- err  out  1  sticky error flag; cleared by the next accepted start.
- err_pc  out  PCW  PC of the faulting instruction.

Behaviour:
- Instruction fields:
  - rs1 = [23:19], rs2 = [18:14], op = [13:9], rd = [8:4].
  - [3:0] is a tag and is ignored.
- Reset state:
  - State IDLE; pc = 0.
  - All outputs 0.
  - All registers 0.
- FSM transitions:
  - IDLE -> (start & prog_len != 0) -> FETCH.
  - IDLE -> (start & prog_len == 0) -> DONE.
  - FETCH: drive imem_addr = pc; next state DECODE.
  - DECODE: latch imem_data. If rs1, rs2 or rd >= NREG: set err, err_pc = pc, go to IDLE. Otherwise latch operands and go to ISSUE.
  - ISSUE: alu_valid = 1. Operands and op are held stable until alu_valid & alu_ready; then go to WAIT. alu_valid drops the cycle after the accept.
  - WAIT: on alu_res_valid, capture alu_res and go to WB. A result arriving in the same cycle as the accept is captured: WAIT is skipped and the FSM goes directly to WB.
  - WB: rf[rd] <= result; pc <= pc + 1. If pc + 1 == prog_len go to DONE, else go to FETCH.
  - DONE: done = 1 for one cycle; then IDLE.
- Hazards: none. Only one operation is in flight, so a read-after-write to the same register sees the written value. rd == rs1 is legal.
- Wrap-around: prog_len > IMEM_DEPTH is clamped to IMEM_DEPTH. pc never wraps.
- Simultaneous events:
  - start while busy is ignored.
  - host_we while busy is dropped.
- Reset mid-operation: returns to IDLE immediately and clears the register file. An in-flight ALU result is discarded.
- Latency: per instruction = 3 + (cycles waiting for alu_ready) + (ALU latency) + 1.

Optional Feature:
- Macro: FP_ISSUE_TIMEOUT_EN.
- When defined: a counter runs in WAIT. If TIMEOUT cycles elapse without alu_res_valid, the block sets err, sets err_pc = pc, returns to IDLE, and does not assert done.
- When undefined: WAIT waits indefinitely and no counter logic exists.

Decomposition:
- Package fp_seq_pkg contains:
  - state enum: IDLE, FETCH, DECODE, ISSUE, WAIT, WB, DONE.
  - instruction field bit positions.
  - opcode constants: OP_FMULT = 5'b00111, OP_FSUB = 5'b00110.
  - DATA_W default.
- Sub-module fp_regfile:
  - NREG x DATA_W entries, async clear.
  - Two combinational read ports, one host read port.
  - One write port, muxed between WB and host preload.

Test Plan:
- Preload R0 = 0x3F800000 and R1 = 0x40000000. Instruction {0, 1, 00111, 2, tag}, prog_len = 1. ALU model: ready = 1, 3-cycle multiply latency. Expect alu_a = 0x3F800000 and alu_b = 0x40000000 at issue, R2 = 0x40000000, a single done pulse, busy low afterwards.
- Two-instruction chain, R2 = R0 * R0 followed by R3 = R2 * R2, with R0 = 0x40000000. Expect the second issue to show alu_a = 0x40800000 and final R3 = 0x41800000.
- Hold alu_ready low for 5 cycles. Expect alu_a, alu_b and alu_op stable throughout and exactly one accept.
- Instruction with rd = 20. Expect err = 1, err_pc = 0, no register write, no done. The next start clears err.
- Pulse start while busy, and assert host_we mid-run with host_addr = 0. Expect both ignored and R0 unchanged.
- With FP_ISSUE_TIMEOUT_EN defined: never assert alu_res_valid. Expect err asserted TIMEOUT cycles after the accept. Separately, drop rst_n during WAIT: all registers read 0 and busy = 0 immediately.

Source files
------------

// File: rtl/fp_seq_pkg.sv
// Shared types and constants for the FP issue sequencer.
// State encoding, instruction layout, opcode names, default data width.
package fp_seq_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [4:0] OP_FMULT = 5'b00111;
  localparam logic [4:0] OP_FSUB  = 5'b00110;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    WB,
    DONE
  } state_e;

  // rs1 [23:19], rs2 [18:14], op [13:9], rd [8:4], tag [3:0]
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] op;
    logic [4:0] rd;
    logic [3:0] tag;
  } instr_t;

endpackage

// File: rtl/fp_regfile.sv
// Register file: NREG x DATA_W, async clear, two operand read ports,
// one host read port, one write port (WB has priority over host preload).
module fp_regfile
  import fp_seq_pkg::*;
#(
  parameter int NREG   = 17,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        ra1_i,
  input  logic [4:0]        ra2_i,
  input  logic [4:0]        hra_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o,
  output logic [DATA_W-1:0] hrd_o,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              host_we_i,
  input  logic [4:0]        host_addr_i,
  input  logic [DATA_W-1:0] host_data_i
);

  localparam logic [5:0] NR = 6'(NREG);

  logic [DATA_W-1:0] rf_q [NREG];
  logic              we;
  logic [4:0]        wa;
  logic [DATA_W-1:0] wd;

  always_comb begin
    rd1_o = '0;
    rd2_o = '0;
    hrd_o = '0;
    if ({1'b0, ra1_i} < NR) rd1_o = rf_q[ra1_i];
    if ({1'b0, ra2_i} < NR) rd2_o = rf_q[ra2_i];
    if ({1'b0, hra_i} < NR) hrd_o = rf_q[hra_i];
  end

  always_comb begin
    we = wb_we_i | host_we_i;
    wa = wb_we_i ? wb_addr_i : host_addr_i;
    wd = wb_we_i ? wb_data_i : host_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (we && ({1'b0, wa} < NR)) begin
      rf_q[wa] <= wd;
    end
  end

endmodule

// File: rtl/fp_issue_sequencer.sv
// In-order single-outstanding sequencer feeding one shared FP ALU.
// Ports: start/prog_len run control, imem_* fetch, alu_* valid/ready
// issue + result strobe, host_* preload/readback, busy/done/err/err_pc
// status. Macro FP_ISSUE_TIMEOUT_EN adds a WAIT-state result timeout.
module fp_issue_sequencer
  import fp_seq_pkg::*;
#(
  parameter int NREG       = 17,
  parameter int IMEM_DEPTH = 16,
  parameter int DATA_W     = DATA_W_DEF,
`ifdef FP_ISSUE_TIMEOUT_EN
  parameter int TIMEOUT    = 64,
`endif
  localparam int PCW       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PCW:0]      prog_len,
  output logic [PCW-1:0]    imem_addr,
  input  logic [23:0]       imem_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_op,
  output logic              alu_valid,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_res_valid,
  input  logic              host_we,
  input  logic [4:0]        host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PCW-1:0]    err_pc
);

  localparam logic [5:0] NR      = 6'(NREG);
  localparam logic [PCW:0] LMAX  = (PCW+1)'(IMEM_DEPTH);

  state_e            state_q, state_d;
  logic [PCW-1:0]    pc_q, pc_d;
  logic [PCW:0]      len_q, len_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0]        op_q, op_d, rd_q, rd_d;
  logic              err_q, err_d;
  logic [PCW-1:0]    epc_q, epc_d;

  instr_t            ins;
  logic              bad;
  logic              last;
  logic              tmo;
  logic              unused_tag;
  logic [DATA_W-1:0] rd1, rd2;

  assign ins        = instr_t'(imem_data);
  assign unused_tag = ^ins.tag;
  assign bad  = ({1'b0, ins.rs1} >= NR) |
                ({1'b0, ins.rs2} >= NR) |
                ({1'b0, ins.rd}  >= NR);
  assign last = ({1'b0, pc_q} + (PCW+1)'(1)) == len_q;

`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  // Counts WAIT cycles; fires on the TIMEOUT-th one with no result.
  assign tmo   = (state_q == WAIT) && !alu_res_valid &&
                 (tmo_q == TW'(TIMEOUT - 1));
  assign tmo_d = (state_q == WAIT) ? tmo_q + TW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start) state_d = (prog_len == '0) ? DONE : FETCH;
      FETCH:  state_d = DECODE;
      DECODE: state_d = bad ? IDLE : ISSUE;
      ISSUE:  if (alu_ready) state_d = alu_res_valid ? WB : WAIT;
      WAIT: begin
        if (alu_res_valid) state_d = WB;
        else if (tmo)      state_d = IDLE;
      end
      WB:     state_d = last ? DONE : FETCH;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      IDLE:  busy      = 1'b0;
      ISSUE: alu_valid = 1'b1;
      DONE:  done      = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    len_d = len_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    rd_d  = rd_q;
    res_d = res_q;
    err_d = err_q;
    epc_d = epc_q;
    unique case (state_q)
      IDLE: if (start) begin
        pc_d  = '0;
        err_d = 1'b0;
        len_d = (prog_len > LMAX) ? LMAX : prog_len;
      end
      DECODE: if (bad) begin
        err_d = 1'b1;
        epc_d = pc_q;
      end else begin
        a_d  = rd1;
        b_d  = rd2;
        op_d = ins.op;
        rd_d = ins.rd;
      end
      ISSUE: if (alu_ready && alu_res_valid) res_d = alu_res;
      WAIT: begin
        if (alu_res_valid) begin
          res_d = alu_res;
        end else if (tmo) begin
          err_d = 1'b1;
          epc_d = pc_q;
        end
      end
      // pc holds on the final instruction so it never wraps
      WB: if (!last) pc_d = pc_q + PCW'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      len_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      rd_q  <= '0;
      res_q <= '0;
      err_q <= 1'b0;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      len_q <= len_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      rd_q  <= rd_d;
      res_q <= res_d;
      err_q <= err_d;
      epc_q <= epc_d;
    end
  end

  fp_regfile #(
    .NREG   (NREG),
    .DATA_W (DATA_W)
  ) u_rf (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra1_i       (ins.rs1),
    .ra2_i       (ins.rs2),
    .hra_i       (host_addr),
    .rd1_o       (rd1),
    .rd2_o       (rd2),
    .hrd_o       (host_rdata),
    .wb_we_i     (state_q == WB),
    .wb_addr_i   (rd_q),
    .wb_data_i   (res_q),
    .host_we_i   (host_we & ~busy),
    .host_addr_i (host_addr),
    .host_data_i (host_wdata)
  );

  assign imem_addr = pc_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign err       = err_q;
  assign err_pc    = epc_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Randomized bench for fp_issue_sequencer with a program-level model.
// Model executes each run in zero time; a compare process checks issues.
`timescale 1ns/1ps
module tb_fp_issue_sequencer;
  import fp_seq_pkg::*;

  localparam int NREG = 17;
  localparam int IMEM_DEPTH = 16;
  localparam int PCW = 4;
`ifdef FP_ISSUE_TIMEOUT_EN
  localparam int TMO = 64;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [PCW:0] prog_len = '0;
  logic [PCW-1:0] imem_addr;
  logic [23:0] imem_data = '0;
  logic [31:0] alu_a, alu_b;
  logic [4:0] alu_op;
  logic alu_valid;
  logic alu_ready = 1'b0;
  logic [31:0] alu_res = '0;
  logic alu_res_valid = 1'b0;
  logic host_we = 1'b0;
  logic [4:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;
  logic busy, done, err;
  logic [PCW-1:0] err_pc;

  always #5 clk = ~clk;

  fp_issue_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_len(prog_len),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_res(alu_res), .alu_res_valid(alu_res_valid),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .busy(busy), .done(done), .err(err), .err_pc(err_pc)
  );

  logic [23:0] imem [IMEM_DEPTH];
  always @(posedge clk) imem_data <= imem[imem_addr];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Environment ALU: powers-of-two multiply exactly, else a hash.
  function automatic logic [31:0] alu_fn(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [4:0] op);
    logic [8:0] e;
    if (op == OP_FMULT && a[22:0] == 0 && b[22:0] == 0 &&
        a[30:23] != 0 && b[30:23] != 0) begin
      e = {1'b0, a[30:23]} + {1'b0, b[30:23]} - 9'd127;
      return {a[31] ^ b[31], e[7:0], 23'd0};
    end
    return (a ^ {b[15:0], b[31:16]}) + {27'd0, op};
  endfunction

  // ---------------- ALU responder ----------------
  int force_rw = -1;
  int force_lat = -1;
  bit never_res = 0;
  int alu_cycles = 0;
  int rw_left = 0;
  int lat_cur = 0;
  int cnt = 0;
  bit in_issue = 0;
  bit acc_prev = 0;
  logic [31:0] pend = '0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      in_issue = 0; acc_prev = 0; cnt = 0;
      alu_ready = 0; alu_res_valid = 0;
    end else begin
      if (acc_prev && lat_cur > 0 && !never_res) cnt = lat_cur;
      acc_prev = 0;
      alu_ready = 0;
      alu_res_valid = 0;
      alu_res = $urandom;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin alu_res_valid = 1; alu_res = pend; end
      end
      if (alu_valid) begin
        if (!in_issue) begin
          in_issue = 1;
          rw_left = (force_rw >= 0) ? force_rw : $urandom_range(0, 3);
          lat_cur = (force_lat >= 0) ? force_lat : $urandom_range(0, 4);
          alu_cycles += rw_left + lat_cur;
        end
        if (rw_left > 0) rw_left--;
        else begin
          alu_ready = 1; acc_prev = 1; in_issue = 0;
          pend = alu_fn(alu_a, alu_b, alu_op);
          if (lat_cur == 0 && !never_res) begin
            alu_res_valid = 1; alu_res = pend;
          end
        end
      end
    end
  end

  // ---------------- model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
  } iss_t;

  iss_t exp_q[$];
  logic [31:0] mrf [NREG];
  logic [31:0] mrf_save [NREG];
  bit m_err = 0;
  int m_epc = 0;
  int acc_count = 0;
  int done_seen = 0;

  task automatic model_run(input int len, output bit e, output int epc,
                           output int nok);
    int n;
    logic [23:0] w;
    int rs1, rs2, rd;
    iss_t t;
    n = (len > IMEM_DEPTH) ? IMEM_DEPTH : len;
    e = 0; epc = 0; nok = 0;
    for (int i = 0; i < n; i++) begin
      w = imem[i];
      rs1 = int'(w[23:19]); rs2 = int'(w[18:14]); rd = int'(w[8:4]);
      if (rs1 >= NREG || rs2 >= NREG || rd >= NREG) begin
        e = 1; epc = i; return;
      end
      t.a = mrf[rs1]; t.b = mrf[rs2]; t.op = w[13:9];
      exp_q.push_back(t);
      mrf[rd] = alu_fn(t.a, t.b, t.op);
      nok++;
    end
  endtask

  // Compare process: every issue cycle must match the model's next issue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_issue", {31'd0, alu_valid}, 32'd0);
        end else begin
          chk("issue_a", alu_a, exp_q[0].a);
          chk("issue_b", alu_b, exp_q[0].b);
          chk("issue_op", {27'd0, alu_op}, {27'd0, exp_q[0].op});
          if (alu_ready) begin
            void'(exp_q.pop_front());
            acc_count++;
          end
        end
      end
      if (done) done_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input int a, input logic [31:0] d);
    @(negedge clk);
    host_we = 1; host_addr = 5'(a); host_wdata = d;
    @(negedge clk);
    host_we = 0;
    if (a < NREG) mrf[a] = d;
  endtask

  task automatic peek(input int r, output logic [31:0] v);
    host_addr = 5'(r);
    #1;
    v = host_rdata;
  endtask

  task automatic check_rf(input string tag);
    logic [31:0] v;
    for (int r = 0; r < 32; r++) begin
      peek(r, v);
      chk($sformatf("%s_rf%0d", tag, r), v, (r < NREG) ? mrf[r] : 32'd0);
    end
  endtask

  task automatic run(input int len, input int inj);
    bit e;
    int epc, nok, cyc, acc0, done0;
    model_run(len, e, epc, nok);
    m_err = e;
    if (e) m_epc = epc;
    alu_cycles = 0;
    acc0 = acc_count;
    done0 = done_seen;
    @(negedge clk);
    start = 1; prog_len = (PCW+1)'(len);
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      cyc++;
      if (cyc == inj) begin
        start = 1; prog_len = 1;
        host_we = 1; host_addr = 0; host_wdata = 32'hDEADBEEF;
      end else begin
        start = 0; host_we = 0;
      end
      @(negedge clk);
    end
    start = 0; host_we = 0;
    if (cyc >= 2000) chk("run_busy_bound", 32'(cyc), 32'd0);
    chk("busy_cycles", 32'(cyc), 32'(nok * 4 + alu_cycles + (e ? 2 : 1)));
    chk("done_pulses", 32'(done_seen - done0), e ? 32'd0 : 32'd1);
    chk("accepts", 32'(acc_count - acc0), 32'(nok));
    chk("err", {31'd0, err}, {31'd0, m_err});
    if (m_err) chk("err_pc", {28'd0, err_pc}, 32'(m_epc));
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_rf("run");
  endtask

  function automatic logic [4:0] rnd_idx();
    if ($urandom_range(0, 19) == 0) return 5'($urandom_range(17, 31));
    return 5'($urandom_range(0, 16));
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    bit e;
    int epc, nok, cyc, done0;
    for (int i = 0; i < IMEM_DEPTH; i++) imem[i] = '0;
    for (int i = 0; i < NREG; i++) mrf[i] = '0;

    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_valid", {31'd0, alu_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_imem_addr", {28'd0, imem_addr}, 32'd0);
    chk("rst_err_pc", {28'd0, err_pc}, 32'd0);
    peek(0, v);
    chk("rst_r0", v, 32'd0);
    rst_n = 1;

    chk("pin_mul_1x2", alu_fn(32'h3F800000, 32'h40000000, OP_FMULT),
        32'h40000000);
    chk("pin_mul_4x4", alu_fn(32'h40800000, 32'h40800000, OP_FMULT),
        32'h41800000);

    // single multiply, ready=1, 3-cycle latency
    preload(0, 32'h3F800000);
    preload(1, 32'h40000000);
    imem[0] = {5'd0, 5'd1, OP_FMULT, 5'd2, 4'hA};
    force_rw = 0; force_lat = 3;
    run(1, 0);
    peek(2, v); chk("t1_r2", v, 32'h40000000);
    chk("t1_busy", {31'd0, busy}, 32'd0);

    // dependent chain
    force_rw = -1; force_lat = -1;
    preload(0, 32'h40000000);
    imem[0] = {5'd0, 5'd0, OP_FMULT, 5'd2, 4'h3};
    imem[1] = {5'd2, 5'd2, OP_FMULT, 5'd3, 4'h4};
    run(2, 0);
    peek(2, v); chk("t2_r2", v, 32'h40800000);
    peek(3, v); chk("t2_r3", v, 32'h41800000);

    // ready held low for 5 cycles
    force_rw = 5; force_lat = 2;
    imem[0] = {5'd1, 5'd0, OP_FSUB, 5'd4, 4'h0};
    run(1, 0);

    // illegal rd, then recovery, then illegal rs1 at pc 2
    force_rw = -1; force_lat = -1;
    imem[0] = {5'd0, 5'd1, OP_FMULT, 5'd20, 4'h0};
    run(1, 0);
    chk("t4_err", {31'd0, err}, 32'd1);
    chk("t4_err_pc", {28'd0, err_pc}, 32'd0);
    imem[0] = {5'd0, 5'd1, OP_FSUB, 5'd5, 4'h0};
    run(1, 0);
    chk("t4_err_clr", {31'd0, err}, 32'd0);
    imem[1] = {5'd5, 5'd1, OP_FSUB, 5'd6, 4'h0};
    imem[2] = {5'd17, 5'd1, OP_FSUB, 5'd6, 4'h0};
    run(3, 0);
    chk("t4b_err_pc", {28'd0, err_pc}, 32'd2);

    // start and host write while busy
    force_rw = 2;
    imem[0] = {5'd1, 5'd1, OP_FSUB, 5'd7, 4'h0};
    run(1, 3);
    peek(0, v); chk("t5_r0", v, 32'h40000000);
    force_rw = -1;

    // zero-length program and clamped length
    run(0, 0);
    for (int k = 0; k < IMEM_DEPTH; k++)
      imem[k] = {5'($urandom_range(0, 16)), 5'($urandom_range(0, 16)),
                 5'($urandom), 5'($urandom_range(0, 16)), 4'($urandom)};
    run(20, 0);

    // random programs
    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < 3; k++)
        preload($urandom_range(0, 20), $urandom);
      for (int k = 0; k < IMEM_DEPTH; k++)
        imem[k] = {rnd_idx(), rnd_idx(),
                   ($urandom_range(0, 1) != 0) ? OP_FMULT : 5'($urandom),
                   rnd_idx(), 4'($urandom)};
      run($urandom_range(0, 18), ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    // reset while waiting for a result
    force_rw = 0; never_res = 1;
    imem[0] = {5'd1, 5'd2, OP_FMULT, 5'd3, 4'h0};
    model_run(1, e, epc, nok);
    @(negedge clk); start = 1; prog_len = 1;
    @(negedge clk); start = 0;
    repeat (5) @(negedge clk);
    chk("t8_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 0;
    #1;
    chk("t8_busy", {31'd0, busy}, 32'd0);
    chk("t8_valid", {31'd0, alu_valid}, 32'd0);
    chk("t8_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    for (int i = 0; i < NREG; i++) mrf[i] = '0;
    m_err = 0;
    check_rf("t8");
    @(negedge clk); rst_n = 1;
    never_res = 0; force_rw = -1;

`ifdef FP_ISSUE_TIMEOUT_EN
    preload(1, 32'h40000000);
    force_rw = 0; never_res = 1;
    imem[0] = {5'd1, 5'd1, OP_FMULT, 5'd3, 4'h0};
    mrf_save = mrf;
    model_run(1, e, epc, nok);
    mrf = mrf_save;
    done0 = done_seen;
    @(negedge clk); start = 1; prog_len = 1;
    @(negedge clk); start = 0;
    cyc = 0;
    while (busy && cyc < 500) begin cyc++; @(negedge clk); end
    chk("tmo_busy_cycles", 32'(cyc), 32'(3 + TMO));
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_err_pc", {28'd0, err_pc}, 32'd0);
    chk("tmo_no_done", 32'(done_seen - done0), 32'd0);
    chk("tmo_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check_rf("tmo");
    never_res = 0; force_rw = -1;
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
